// File: rtl/nco_pkg.sv
// nco_pkg: shared NCO widths and the frequency-estimator state type.
// Imported by the estimator, its sample interface and the benches.
package nco_pkg;

    localparam int DATA_W  = 13;
    localparam int PHASE_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_COUNT,
        ST_DIV,
        ST_DONE
    } nco_est_state_t;

endpackage

// File: rtl/nco_freq_est_if.sv
// nco_freq_est_if: NCO sample stream (clken, in_valid, sin_i, cos_i).
// master drives the stream (NCO / bench), slave consumes it (estimator).
interface nco_freq_est_if #(
    parameter int DATA_W = nco_pkg::DATA_W
);

    logic                     clken;
    logic                     in_valid;
    logic signed [DATA_W-1:0] sin_i;
    logic signed [DATA_W-1:0] cos_i;

    modport master (
        output clken,
        output in_valid,
        output sin_i,
        output cos_i
    );

    modport slave (
        input clken,
        input in_valid,
        input sin_i,
        input cos_i
    );

endinterface

// File: rtl/seq_udiv.sv
// seq_udiv: unsigned restoring divider, one quotient bit per clk.
// Ports: clk, reset_n (sync, active-low), i_start, i_num, i_den,
// o_busy, o_done (high in the cycle of the final iteration), o_quot.
// Only the low Q_W quotient bits are produced; the caller must
// guarantee i_num >> Q_W < i_den so the upper quotient bits are zero.
module seq_udiv #(
    parameter int N_W = 35,
    parameter int D_W = 24,
    parameter int Q_W = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           i_start,
    input  logic [N_W-1:0] i_num,
    input  logic [D_W-1:0] i_den,
    output logic           o_busy,
    output logic           o_done,
    output logic [Q_W-1:0] o_quot
);

    localparam int C_W = $clog2(Q_W + 1);

    logic [D_W-1:0] r_rem;
    logic [D_W-1:0] r_den;
    logic [Q_W-1:0] r_num;
    logic [Q_W-1:0] r_quot;
    logic [C_W-1:0] r_count;
    logic           r_busy;

    logic [D_W-1:0] w_num_hi;
    logic [D_W:0]   w_shift;
    logic [D_W-1:0] w_diff;
    logic           w_ge;

    // Upper numerator bits seed the remainder directly.
    assign w_num_hi = D_W'(i_num[N_W-1:Q_W]);
    assign w_shift  = {r_rem, r_num[Q_W-1]};
    assign w_ge     = w_shift >= {1'b0, r_den};
    // When w_ge the difference is below r_den, so D_W bits suffice.
    assign w_diff   = w_shift[D_W-1:0] - r_den;

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_count == C_W'(1));
    assign o_quot = r_quot;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rem   <= '0;
            r_den   <= '0;
            r_num   <= '0;
            r_quot  <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_rem   <= w_num_hi;
            r_den   <= i_den;
            r_num   <= i_num[Q_W-1:0];
            r_quot  <= '0;
            r_count <= C_W'(Q_W);
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_rem   <= w_ge ? w_diff : w_shift[D_W-1:0];
            r_num   <= {r_num[Q_W-2:0], 1'b0};
            r_quot  <= {r_quot[Q_W-2:0], w_ge};
            r_count <= r_count - C_W'(1);
            r_busy  <= (r_count != C_W'(1));
        end
    end

endmodule

// File: rtl/nco_freq_est.sv
// nco_freq_est: recovers the NCO phase increment from its sin/cos stream.
// Ports: clk, reset_n (sync, active-low), smp (slave sample stream),
// start, busy, done, err, phi_est = NPER*2^PHASE_W/period_cnt, period_cnt.
module nco_freq_est #(
    parameter int DATA_W  = nco_pkg::DATA_W,
    parameter int PHASE_W = nco_pkg::PHASE_W,
    parameter int NPER    = 4,
    parameter int CNT_W   = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    nco_freq_est_if.slave      smp,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [PHASE_W-1:0] phi_est,
    output logic [CNT_W-1:0]   period_cnt
);

    import nco_pkg::*;

    localparam int NP_W = $clog2(NPER);
    localparam int N_W  = PHASE_W + NP_W + 1;
    localparam int X_W  = $clog2(NPER + 1);

    localparam logic [N_W-1:0]   DIV_NUM  = N_W'(NPER) << PHASE_W;
    localparam logic [CNT_W-1:0] CNT_TOP  = '1;
    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(2 * NPER);
    localparam logic signed [DATA_W-1:0] ZERO = '0;

    nco_est_state_t r_state;
    nco_est_state_t w_state_nx;

    logic signed [DATA_W-1:0] r_sin_prev;
    logic [CNT_W-1:0]         r_cnt;
    logic [X_W-1:0]           r_ncross;
    logic [CNT_W-1:0]         r_period;
    logic [PHASE_W-1:0]       r_phi;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;

    logic               w_s;
    logic               w_xc;
    logic               w_last_xc;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_cnt_top;
    logic               w_div_start;
    logic               w_div_busy;
    logic               w_div_done;
    logic [PHASE_W-1:0] w_quot;
    logic               w_fail;
    logic               w_finish;

    assign w_s = smp.clken & smp.in_valid;

    // Positive-going crossing; cos>0 rejects noise and negative frequency.
    assign w_xc = w_s && (r_sin_prev < ZERO) &&
                  (smp.sin_i >= ZERO) && (smp.cos_i > ZERO);

    assign w_last_xc = w_xc && (r_ncross == X_W'(NPER - 1));
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_cnt_top = (w_cnt_inc == CNT_TOP);

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign phi_est    = r_phi;
    assign period_cnt = r_period;

    // Divisor is the count including the final crossing sample, so the
    // divide starts on the same edge that leaves COUNT.
    seq_udiv #(
        .N_W (N_W),
        .D_W (CNT_W),
        .Q_W (PHASE_W)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (w_div_start),
        .i_num   (DIV_NUM),
        .i_den   (w_cnt_inc),
        .o_busy  (w_div_busy),
        .o_done  (w_div_done),
        .o_quot  (w_quot)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_div_start = 1'b0;
        w_fail      = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_nx = ST_ARM;
            end
            ST_ARM: begin
                if (w_xc) begin
                    w_state_nx = ST_COUNT;
                end else if (w_s && w_cnt_top) begin
                    w_fail     = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (w_last_xc) begin
                    w_div_start = 1'b1;
                    w_state_nx  = ST_DIV;
                end else if (w_s && w_cnt_top) begin
                    w_fail     = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
            ST_DIV: begin
                // Aliased count, or a divider that never ran, aborts.
                if ((r_period < CNT_MIN) || !w_div_busy) begin
                    w_fail     = 1'b1;
                    w_state_nx = ST_IDLE;
                end else if (w_div_done) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                w_finish   = 1'b1;
                w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_sin_prev <= '0;
            r_cnt      <= '0;
            r_ncross   <= '0;
            r_period   <= '0;
            r_phi      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_done  <= w_finish;
            r_err   <= w_fail;
            if (w_finish) r_phi <= w_quot;
            if ((r_state == ST_IDLE) && start) begin
                r_busy     <= 1'b1;
                r_cnt      <= '0;
                r_ncross   <= '0;
                r_sin_prev <= '0;
            end else begin
                if (w_fail || w_finish) r_busy <= 1'b0;
                if (w_s) r_sin_prev <= smp.sin_i;
                if (r_state == ST_ARM) begin
                    if (w_xc) begin
                        r_cnt    <= '0;
                        r_ncross <= '0;
                    end else if (w_s) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                if ((r_state == ST_COUNT) && w_s) begin
                    r_cnt <= w_cnt_inc;
                    if (w_xc) r_ncross <= r_ncross + X_W'(1);
                    if (w_last_xc) r_period <= w_cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_nco_freq_est.sv
// tb_nco_freq_est: directed vectors for nco_freq_est (CNT_W=24 and 8).
// Table of synthetic streams plus timeout and mid-divide reset cases.
module tb_nco_freq_est;

    import nco_pkg::*;

    localparam int  NPER   = 4;
    localparam int  BUDGET = 4000;
    localparam int  K_SINE = 0;
    localparam int  K_NEG  = 1;
    localparam int  K_ALT2 = 2;
    localparam int  K_ZERO = 3;
    localparam real TWO_PI = 6.283185307179586;

    typedef struct {
        int          kind;
        int          per;
        int          vmode;
        int          lowpct;
        int          exp_cnt;
        logic [31:0] exp_phi;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;

    logic               busy, done, err;
    logic [PHASE_W-1:0] phi_est;
    logic [23:0]        period_cnt;
    logic               busy8, done8, err8;
    logic [PHASE_W-1:0] phi8;
    logic [7:0]         period8;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   n_idx, fed, m_nx, xc_cyc;
    logic m_neg;
    vec_t vecs[6];

    nco_freq_est_if #(.DATA_W(DATA_W)) smp ();

    nco_freq_est #(
        .DATA_W(DATA_W), .PHASE_W(PHASE_W), .NPER(NPER), .CNT_W(24)
    ) dut (
        .clk(clk), .reset_n(reset_n), .smp(smp), .start(start),
        .busy(busy), .done(done), .err(err),
        .phi_est(phi_est), .period_cnt(period_cnt)
    );

    nco_freq_est #(
        .DATA_W(DATA_W), .PHASE_W(PHASE_W), .NPER(NPER), .CNT_W(8)
    ) dut8 (
        .clk(clk), .reset_n(reset_n), .smp(smp), .start(start),
        .busy(busy8), .done(done8), .err(err8),
        .phi_est(phi8), .period_cnt(period8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic void gen(input int kind, input int per, input int n,
                                output logic signed [DATA_W-1:0] s,
                                output logic signed [DATA_W-1:0] c);
        real ph;
        s = '0;
        c = '0;
        if (kind == K_SINE || kind == K_NEG) begin
            ph = TWO_PI * real'(n) / real'(per);
            s  = DATA_W'(rnd(4095.0 * $sin(ph)));
            c  = DATA_W'(rnd(4095.0 * $cos(ph)));
            if (kind == K_NEG) s = -s;
        end else if (kind == K_ALT2) begin
            s = (n % 2 == 1) ? DATA_W'(-100) : DATA_W'(0);
            c = DATA_W'(100);
        end
    endfunction

    task automatic reset_model();
        m_neg  = 1'b0;
        m_nx   = 0;
        xc_cyc = -1;
        n_idx  = 1;
        fed    = 0;
    endtask

    // Non-strobed cycles carry random data that must be ignored.
    task automatic drive_sample(input int kind, input int per,
                                input int vmode, input int lowpct);
        logic signed [DATA_W-1:0] s, c;
        logic v, ce;
        v  = (vmode == 0) ? 1'b1 : ((cyc % 2) == 0);
        ce = ($urandom_range(99) >= 32'(lowpct));
        smp.in_valid = v;
        smp.clken    = ce;
        if (v && ce) begin
            gen(kind, per, n_idx, s, c);
            if (m_neg && s >= 0 && c > 0) begin
                m_nx++;
                if (m_nx == NPER + 1) xc_cyc = cyc;
            end
            m_neg = (s < 0);
            n_idx++;
            fed++;
        end else begin
            s = DATA_W'($urandom);
            c = DATA_W'($urandom);
        end
        smp.sin_i = s;
        smp.cos_i = c;
    endtask

    task automatic do_start();
        tick();
        start        = 1'b1;
        smp.in_valid = 1'b0;
        smp.clken    = 1'b1;
        reset_model();
        tick();
        start = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit    got_d, got_e;
        int    t_end;
        string tag;
        tag = $sformatf("v%0d", idx);
        do_start();
        chk({tag, "_busy_start"}, 64'(busy), 64'(1));
        got_d = 1'b0;
        got_e = 1'b0;
        t_end = -1;
        for (int i = 0; i < BUDGET; i++) begin
            if (done || err) begin
                got_d = done;
                got_e = err;
                t_end = cyc;
                break;
            end
            drive_sample(v.kind, v.per, v.vmode, v.lowpct);
            tick();
        end
        smp.in_valid = 1'b0;
        chk({tag, "_done"}, 64'(got_d), 64'(1));
        chk({tag, "_err"}, 64'(got_e), 64'(0));
        chk({tag, "_busy_end"}, 64'(busy), 64'(0));
        chk({tag, "_period_cnt"}, 64'(period_cnt), 64'(v.exp_cnt));
        chk({tag, "_phi_est"}, 64'(phi_est), 64'(v.exp_phi));
        chk({tag, "_latency"}, 64'(t_end - xc_cyc), 64'(PHASE_W + 2));
        tick();
        chk({tag, "_done_pulse"}, 64'(done), 64'(0));
        chk({tag, "_phi_hold"}, 64'(phi_est), 64'(v.exp_phi));
    endtask

    task automatic timeout_test(input int kind, input string tag);
        bit got, saw_done;
        int fed_at;
        do_start();
        chk({tag, "_busy_start"}, 64'(busy8), 64'(1));
        got      = 1'b0;
        saw_done = 1'b0;
        fed_at   = -1;
        for (int i = 0; i < 600; i++) begin
            if (err8) begin
                got    = 1'b1;
                fed_at = fed;
                break;
            end
            if (done8) saw_done = 1'b1;
            drive_sample(kind, 100, 0, 0);
            tick();
        end
        smp.in_valid = 1'b0;
        chk({tag, "_err"}, 64'(got), 64'(1));
        chk({tag, "_samples"}, 64'(fed_at), 64'(255));
        chk({tag, "_busy"}, 64'(busy8), 64'(0));
        chk({tag, "_no_done"}, 64'(saw_done | done8), 64'(0));
        chk({tag, "_phi_kept"}, 64'(phi8), 64'(32'h1999_9999));
        chk({tag, "_cnt_kept"}, 64'(period8), 64'(40));
        tick();
        chk({tag, "_err_pulse"}, 64'(err8), 64'(0));
    endtask

    initial begin
        bit pulse;

        vecs[0] = '{K_SINE, 100, 0,  0, 400, 32'h028F_5C28};
        vecs[1] = '{K_SINE, 100, 1, 30, 400, 32'h028F_5C28};
        vecs[2] = '{K_SINE,  50, 0,  0, 200, 32'h051E_B851};
        vecs[3] = '{K_SINE,  64, 1,  0, 256, 32'h0400_0000};
        vecs[4] = '{K_ALT2,   2, 0, 20,   8, 32'h8000_0000};
        vecs[5] = '{K_SINE,  10, 0,  0,  40, 32'h1999_9999};

        smp.in_valid = 1'b0;
        smp.clken    = 1'b0;
        smp.sin_i    = '0;
        smp.cos_i    = '0;
        reset_model();

        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_phi", 64'(phi_est), 64'(0));
        chk("rst_cnt", 64'(period_cnt), 64'(0));
        chk("rst8_busy", 64'(busy8), 64'(0));
        chk("rst8_err", 64'(err8), 64'(0));
        chk("rst8_phi", 64'(phi8), 64'(0));
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        timeout_test(K_NEG, "to_negfreq");
        timeout_test(K_ZERO, "to_zero");

        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        run_vec(6, vecs[0]);

        do_start();
        for (int i = 0; i < BUDGET && xc_cyc < 0; i++) begin
            drive_sample(K_SINE, 100, 0, 0);
            tick();
        end
        smp.in_valid = 1'b0;
        chk("abort_reach_div", 64'(xc_cyc >= 0), 64'(1));
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_err", 64'(err), 64'(0));
        chk("abort_phi", 64'(phi_est), 64'(0));
        chk("abort_cnt", 64'(period_cnt), 64'(0));
        pulse = 1'b0;
        repeat (40) begin
            tick();
            if (done || err) pulse = 1'b1;
        end
        chk("abort_no_pulse", 64'(pulse), 64'(0));
        run_vec(7, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
